mmu_arbiter: RTL and testbench

MMU_ARBITER -- requirements
Module: mmu_arbiter

---
 rtl/mmu_arbiter_pkg.sv | 35 +++
 rtl/mmu_arbiter.sv | 103 ++++++++++
 tb/tb_mmu_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_arbiter_pkg.sv
// Shared encodings for the L1I/L1D arbiter in front of the l1mmu.
// Kept in a package so top-level debug logic can decode state and grant.
package mmu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IC = 2'd1,
        ST_BUSY_DC = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IC = 1'b0,
        GRANT_DC = 1'b1
    } grant_t;

    // Winner among the active requesters; on a tie the side that was not
    // granted last time wins. Result is only meaningful when one is active.
    function automatic grant_t pick_winner(
        input logic   ic_active,
        input logic   dc_active,
        input grant_t last_grant
    );
        grant_t winner;
        if (ic_active && dc_active) begin
            winner = (last_grant == GRANT_IC) ? GRANT_DC : GRANT_IC;
        end else if (dc_active) begin
            winner = GRANT_DC;
        end else begin
            winner = GRANT_IC;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing one l1mmu port between the L1I and L1D.
// A grant latches the winner's request into registers that drive mmu_*;
// completion is passed back combinationally, followed by one RELEASE cycle
// so the requester can drop its request before the next arbitration.
module mmu_arbiter
    import mmu_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              sys_clk,
    input  logic              rst_n,

    input  logic              ic_req_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_read_data,

    input  logic              dc_req_read,
    input  logic              dc_req_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_read_data,

    output logic              mmu_read,
    output logic              mmu_write,
    output logic [ADDR_W-1:0] mmu_addr,
    output logic [LINE_W-1:0] mmu_write_data,
    input  logic              mmu_done,
    input  logic [LINE_W-1:0] mmu_read_data
);

    arb_state_t state;
    grant_t     last_grant;
    grant_t     winner;
    logic       ic_active;
    logic       dc_active;

    // Requester activity and the round-robin pick for the current cycle.
    always_comb begin
        ic_active = ic_req_read;
        dc_active = dc_req_read | dc_req_write;
        winner    = pick_winner(ic_active, dc_active, last_grant);
    end

    // Arbitration FSM; mmu_* request registers are loaded only at grant.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            last_grant     <= GRANT_IC;
            mmu_read       <= 1'b0;
            mmu_write      <= 1'b0;
            mmu_addr       <= '0;
            mmu_write_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ic_active || dc_active) begin
                        last_grant <= winner;
                        if (winner == GRANT_DC) begin
                            state          <= ST_BUSY_DC;
                            mmu_read       <= dc_req_read;
                            mmu_write      <= dc_req_write;
                            mmu_addr       <= dc_addr;
                            mmu_write_data <= dc_write_data;
                        end else begin
                            state          <= ST_BUSY_IC;
                            mmu_read       <= 1'b1;
                            mmu_write      <= 1'b0;
                            mmu_addr       <= ic_addr;
                            mmu_write_data <= '0;
                        end
                    end
                end
                ST_BUSY_IC, ST_BUSY_DC: begin
                    // Requests stay up through the done cycle, even if the
                    // requester has already let go of its request.
                    if (mmu_done) begin
                        state     <= ST_RELEASE;
                        mmu_read  <= 1'b0;
                        mmu_write <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Same-cycle completion to the granted side; read data fans out to both.
    always_comb begin
        ic_done      = (state == ST_BUSY_IC) && mmu_done;
        dc_done      = (state == ST_BUSY_DC) && mmu_done;
        ic_read_data = mmu_read_data;
        dc_read_data = mmu_read_data;
    end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Scoreboard bench for mmu_arbiter: stimulus pushes expected MMU requests and
// done responses; a monitor pops and compares on each request rise / done.
module tb_mmu_arbiter;
    import mmu_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              sys_clk;
    logic              rst_n;
    logic              ic_req_read;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic [LINE_W-1:0] ic_read_data;
    logic              dc_req_read;
    logic              dc_req_write;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_done;
    logic [LINE_W-1:0] dc_read_data;
    logic              mmu_read;
    logic              mmu_write;
    logic [ADDR_W-1:0] mmu_addr;
    logic [LINE_W-1:0] mmu_write_data;
    logic              mmu_done;
    logic [LINE_W-1:0] mmu_read_data;

    logic auto_done;
    logic stray_done;
    logic auto_mmu;
    assign mmu_done = auto_done | stray_done;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wd;
    } req_t;

    typedef struct {
        logic              dc;
        logic [LINE_W-1:0] data;
    } done_t;

    req_t  exp_req[$];
    done_t exp_done[$];

    int unsigned checks;
    int unsigned passes;
    int unsigned ic_cnt;
    int unsigned dc_cnt;
    int unsigned cyc;
    int unsigned last_rise_cyc;
    int unsigned last_dc_done_cyc;

    mmu_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .ic_req_read   (ic_req_read),
        .ic_addr       (ic_addr),
        .ic_done       (ic_done),
        .ic_read_data  (ic_read_data),
        .dc_req_read   (dc_req_read),
        .dc_req_write  (dc_req_write),
        .dc_addr       (dc_addr),
        .dc_write_data (dc_write_data),
        .dc_done       (dc_done),
        .dc_read_data  (dc_read_data),
        .mmu_read      (mmu_read),
        .mmu_write     (mmu_write),
        .mmu_addr      (mmu_addr),
        .mmu_write_data(mmu_write_data),
        .mmu_done      (mmu_done),
        .mmu_read_data (mmu_read_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return {8{a}};
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: event with empty scoreboard", name);
    endtask

    task automatic expect_txn(input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] addr,
                              input logic [LINE_W-1:0] wd, input logic dc);
        req_t  r;
        done_t d;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd;
        d.dc = dc; d.data = line_of(addr);
        exp_req.push_back(r);
        exp_done.push_back(d);
    endtask

    // Waits (bounded) for one done pulse on a side, then drops the requested
    // sides during the following RELEASE cycle.
    task automatic wait_done(input logic side_dc, input logic drop_ic,
                             input logic drop_dc);
        int unsigned start;
        int unsigned now;
        start = side_dc ? dc_cnt : ic_cnt;
        now   = start;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk); #1;
            now = side_dc ? dc_cnt : ic_cnt;
            if (now != start) break;
        end
        if (side_dc) chk("dc_done_seen", now - start, 1);
        else         chk("ic_done_seen", now - start, 1);
        @(posedge sys_clk); #2;
        if (drop_ic) ic_req_read = 1'b0;
        if (drop_dc) begin
            dc_req_read  = 1'b0;
            dc_req_write = 1'b0;
        end
    endtask

    // l1mmu model: done arrives 3 cycles after a request rises.
    initial begin
        auto_done     = 1'b0;
        mmu_read_data = '0;
        forever begin
            @(negedge sys_clk);
            if (auto_mmu && (mmu_read || mmu_write)) begin
                logic [LINE_W-1:0] resp;
                resp = line_of(mmu_addr);
                repeat (3) begin @(posedge sys_clk); #2; end
                mmu_read_data = resp;
                auto_done     = 1'b1;
                @(posedge sys_clk); #2;
                auto_done     = 1'b0;
                mmu_read_data = '0;
            end
        end
    end

    // Monitor: compares request rises and done pulses against the scoreboard.
    initial begin
        logic  req_prev;
        req_t  er;
        done_t ed;
        req_prev = 1'b0;
        cyc = 0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if ((mmu_read || mmu_write) && !req_prev) begin
                last_rise_cyc = cyc;
                if (exp_req.size() == 0) fail_now("req_unexpected");
                else begin
                    er = exp_req.pop_front();
                    chk("req_read", mmu_read, er.rd);
                    chk("req_write", mmu_write, er.wr);
                    chk("req_addr", mmu_addr, er.addr);
                    chk("req_wdata", mmu_write_data, er.wd);
                end
            end
            req_prev = mmu_read || mmu_write;
            if (ic_done || dc_done) begin
                if (ic_done) ic_cnt++;
                if (dc_done) begin
                    dc_cnt++;
                    last_dc_done_cyc = cyc;
                end
                if (exp_done.size() == 0) fail_now("done_unexpected");
                else begin
                    ed = exp_done.pop_front();
                    chk("done_side", {ic_done, dc_done}, ed.dc ? 2'b01 : 2'b10);
                    chk("done_data", ed.dc ? dc_read_data : ic_read_data, ed.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned start;
        logic hi_ok;
        checks = 0; passes = 0; ic_cnt = 0; dc_cnt = 0;
        last_rise_cyc = 0; last_dc_done_cyc = 0;
        rst_n = 1'b0; auto_mmu = 1'b1; stray_done = 1'b0;
        ic_req_read = 1'b0; ic_addr = '0;
        dc_req_read = 1'b0; dc_req_write = 1'b0; dc_addr = '0; dc_write_data = '0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        #1;
        chk("rst_flags", {mmu_read, mmu_write, ic_done, dc_done}, 4'b0);
        chk("rst_addr", mmu_addr, 0);
        chk("rst_wdata", mmu_write_data, 0);

        // Tie right after reset: DC first, IC after RELEASE+IDLE
        @(posedge sys_clk); #2;
        rst_n = 1'b1;
        ic_addr = 32'h1000; dc_addr = 32'h2000;
        ic_req_read = 1'b1; dc_req_read = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h2000, '0, 1'b1);
        expect_txn(1'b1, 1'b0, 32'h1000, '0, 1'b0);
        wait_done(1'b1, 1'b0, 1'b1);
        wait_done(1'b0, 1'b1, 1'b0);
        chk("tie_ic_gap", last_rise_cyc - last_dc_done_cyc, 3);

        // Lone IC read, 1-cycle request latency, then RELEASE
        repeat (2) @(posedge sys_clk);
        #2;
        start = ic_cnt;
        ic_addr = 32'h1000; ic_req_read = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h1000, '0, 1'b0);
        @(negedge sys_clk); #1;
        chk("lat_idle_read", mmu_read, 0);
        @(negedge sys_clk); #1;
        chk("lat_read", mmu_read, 1);
        chk("lat_addr", mmu_addr, 32'h1000);
        wait_done(1'b0, 1'b1, 1'b0);
        @(negedge sys_clk); #1;
        chk("rel_state", dut.state, ST_RELEASE);
        chk("rel_req", {mmu_read, mmu_write}, 2'b00);
        @(negedge sys_clk); #1;
        chk("rel_to_idle", dut.state, ST_IDLE);
        repeat (3) @(negedge sys_clk);
        chk("ic_done_once", ic_cnt - start, 1);

        // Alternation with both held: DC, IC, DC, IC
        @(posedge sys_clk); #2;
        ic_addr = 32'h3000; dc_addr = 32'h4000;
        ic_req_read = 1'b1; dc_req_read = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h4000, '0, 1'b1);
        expect_txn(1'b1, 1'b0, 32'h3000, '0, 1'b0);
        expect_txn(1'b1, 1'b0, 32'h4000, '0, 1'b1);
        expect_txn(1'b1, 1'b0, 32'h3000, '0, 1'b0);
        wait_done(1'b1, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0);
        wait_done(1'b1, 1'b0, 1'b0);
        wait_done(1'b0, 1'b1, 1'b1);

        // DC write-back, then read+write forwarded together
        repeat (2) @(posedge sys_clk);
        #2;
        dc_addr = 32'h5000; dc_write_data = {32{8'hA5}}; dc_req_write = 1'b1;
        expect_txn(1'b0, 1'b1, 32'h5000, {32{8'hA5}}, 1'b1);
        wait_done(1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge sys_clk);
        #2;
        dc_addr = 32'h5040; dc_write_data = {16{16'h3C5A}};
        dc_req_read = 1'b1; dc_req_write = 1'b1;
        expect_txn(1'b1, 1'b1, 32'h5040, {16{16'h3C5A}}, 1'b1);
        wait_done(1'b1, 1'b0, 1'b1);

        // IC request dropped mid-BUSY
        repeat (2) @(posedge sys_clk);
        #2;
        start = ic_cnt;
        ic_addr = 32'h6000; ic_req_read = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h6000, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk); #1;
            if (mmu_read) break;
        end
        chk("drop_rise", mmu_read, 1);
        @(posedge sys_clk); #2;
        ic_req_read = 1'b0;
        hi_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk); #1;
            if (!mmu_read) hi_ok = 1'b0;
            if (ic_cnt != start) break;
        end
        chk("drop_read_held", hi_ok, 1);
        repeat (3) @(negedge sys_clk);
        chk("drop_done_once", ic_cnt - start, 1);

        // Reset mid-BUSY_IC, then a stray mmu_done
        auto_mmu = 1'b0;
        @(posedge sys_clk); #2;
        begin
            req_t r;
            r.rd = 1'b1; r.wr = 1'b0; r.addr = 32'h7000; r.wd = '0;
            exp_req.push_back(r);
        end
        ic_addr = 32'h7000; ic_req_read = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;
        chk("rstb_busy", dut.state, ST_BUSY_IC);
        rst_n = 1'b0;
        ic_req_read = 1'b0;
        #1;
        chk("rstb_flags", {mmu_read, mmu_write, ic_done, dc_done}, 4'b0);
        chk("rstb_addr", mmu_addr, 0);
        chk("rstb_state", dut.state, ST_IDLE);
        repeat (2) @(posedge sys_clk);
        #2;
        rst_n = 1'b1;
        @(posedge sys_clk); #2;
        stray_done = 1'b1;
        @(negedge sys_clk); #1;
        chk("stray_no_done", {ic_done, dc_done, mmu_read, mmu_write}, 4'b0);
        @(posedge sys_clk); #2;
        stray_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("stray_idle", dut.state, ST_IDLE);

        chk("sb_empty", exp_req.size() + exp_done.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
